// File: rtl/auro_pkt_framer.sv
// Packs FWFT ADC words and encoder heads into framed AXI-stream packets:
// per sample a header beat plus BEAT_PER_SMP data beats, then one tail beat per packet.
module auro_pkt_framer #(
    parameter int RD_DATA_WD   = 128,
    parameter int HEAD_WD      = 64,
    parameter int BEAT_PER_SMP = 4,
    parameter int PKT_SMP      = 16,
    parameter int FLUSH_TO     = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_rst,
    input  logic                  adc_fifo_empty,
    input  logic [RD_DATA_WD-1:0] adc_fifo_din,
    output logic                  adc_fifo_rd,
    input  logic [HEAD_WD-1:0]    head_din,
    output logic                  head_rd,
    output logic [RD_DATA_WD-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [31:0]           pkt_cnt,
    output logic                  busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DAT  = 2'd2;
    localparam logic [1:0] TAIL = 2'd3;

    localparam int          BCW        = (BEAT_PER_SMP > 1) ? $clog2(BEAT_PER_SMP) : 1;
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEAT_PER_SMP - 1);
    localparam logic [15:0] PKT_SMP_C  = 16'(PKT_SMP);
    localparam logic [31:0] FLUSH_LAST = 32'(FLUSH_TO - 1);
    localparam logic [31:0] HDR_SYNC   = 32'hEB90_55AA;
    localparam logic [31:0] TAIL_SYNC  = 32'hEB90_AA55;

    logic [1:0]            state_q, state_d;
    logic [15:0]           smp_cnt_q, smp_cnt_d;
    logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [31:0]           pkt_seq_q, pkt_seq_d;
    logic [31:0]           to_cnt_q, to_cnt_d;
    logic [RD_DATA_WD-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic [31:0]           pkt_cnt_q;

    logic                  out_free;
    logic                  load;
    logic                  load_last;
    logic [RD_DATA_WD-1:0] load_data;
    logic                  rd_c;
    logic                  hrd_c;

    function automatic logic [RD_DATA_WD-1:0] hdr_beat(input logic [31:0] seq,
                                                       input logic [HEAD_WD-1:0] head);
        logic [RD_DATA_WD-1:0] b;
        b = '0;
        b[RD_DATA_WD-1 -: 32]  = HDR_SYNC;
        b[RD_DATA_WD-33 -: 32] = seq;
        b[HEAD_WD-1:0]         = head;
        return b;
    endfunction

    function automatic logic [RD_DATA_WD-1:0] tail_beat(input logic [31:0] seq,
                                                        input logic [15:0] smp);
        logic [RD_DATA_WD-1:0] b;
        b = '0;
        b[RD_DATA_WD-1 -: 32]  = TAIL_SYNC;
        b[RD_DATA_WD-33 -: 32] = seq;
        b[RD_DATA_WD-65 -: 32] = {16'h0, smp};
        return b;
    endfunction

    assign out_free = !tvalid_q || m_axis_tready;

    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        beat_cnt_d = beat_cnt_q;
        pkt_seq_d  = pkt_seq_q;
        to_cnt_d   = to_cnt_q;
        load       = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        rd_c       = 1'b0;
        hrd_c      = 1'b0;
        case (state_q)
            IDLE: begin
                // Fresh data outranks an expiring flush timer.
                if (smp_cnt_q == PKT_SMP_C) begin
                    state_d = TAIL;
                end else if (!adc_fifo_empty) begin
                    state_d = HDR;
                end else if (smp_cnt_q != 16'd0 && to_cnt_q == FLUSH_LAST) begin
                    state_d = TAIL;
                end else if (smp_cnt_q != 16'd0) begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
                if (state_d != IDLE) begin
                    to_cnt_d = '0;
                end
            end
            HDR: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = hdr_beat(pkt_seq_q, head_din);
                    state_d   = DAT;
                end
            end
            DAT: begin
                if (out_free && !adc_fifo_empty) begin
                    load      = 1'b1;
                    load_data = adc_fifo_din;
                    rd_c      = 1'b1;
                    // Head entry is retired with the last word so the combined empty stays word-accurate.
                    if (beat_cnt_q == BEAT_LAST) begin
                        hrd_c      = 1'b1;
                        beat_cnt_d = '0;
                        smp_cnt_d  = smp_cnt_q + 16'd1;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            TAIL: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    load_data = tail_beat(pkt_seq_q, smp_cnt_q);
                    smp_cnt_d = '0;
                    pkt_seq_d = pkt_seq_q + 32'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            smp_cnt_q  <= '0;
            beat_cnt_q <= '0;
            pkt_seq_q  <= '0;
            to_cnt_q   <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            pkt_cnt_q  <= '0;
        end else if (cfg_rst) begin
            state_q    <= IDLE;
            smp_cnt_q  <= '0;
            beat_cnt_q <= '0;
            pkt_seq_q  <= '0;
            to_cnt_q   <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_seq_q  <= pkt_seq_d;
            to_cnt_q   <= to_cnt_d;
            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= load_data;
                tlast_q  <= load_last;
            end else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
            if (tvalid_q && m_axis_tready && tlast_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign adc_fifo_rd   = rd_c && !cfg_rst;
    assign head_rd       = hrd_c && !cfg_rst;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign busy          = (state_q != IDLE) || (smp_cnt_q != 16'd0);

endmodule

// File: tb/tb_auro_pkt_framer.sv
// Scoreboard bench for auro_pkt_framer: FWFT FIFO models feed the DUT, expected beats are queued
// as samples are issued and a negedge monitor pops and compares every accepted beat.
module tb_auro_pkt_framer;

    localparam int W    = 128;
    localparam int HW   = 64;
    localparam int BPS  = 4;
    localparam int PSMP = 2;
    localparam int FTO  = 64;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_rst = 1'b0;
    logic          adc_fifo_empty = 1'b1;
    logic [W-1:0]  adc_fifo_din = '0;
    logic          adc_fifo_rd;
    logic [HW-1:0] head_din = '0;
    logic          head_rd;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [31:0]   pkt_cnt;
    logic          busy;

    auro_pkt_framer #(
        .RD_DATA_WD(W), .HEAD_WD(HW), .BEAT_PER_SMP(BPS), .PKT_SMP(PSMP), .FLUSH_TO(FTO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst),
        .adc_fifo_empty(adc_fifo_empty), .adc_fifo_din(adc_fifo_din), .adc_fifo_rd(adc_fifo_rd),
        .head_din(head_din), .head_rd(head_rd),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int adc_pops = 0;
    int head_pops = 0;
    int prev_acc = 0;
    int tail_gap = 0;
    logic rand_ready = 1'b0;
    logic rd_s = 1'b0;
    logic hrd_s = 1'b0;
    logic stall_prev = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    logic [W-1:0]  adc_q[$];
    logic [HW-1:0] head_q[$];
    beat_t         exp_q[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] word(input int s, input int b);
        return {32'hC0DE_0000 + 32'(s), 32'(b), ~32'(s), 32'h1234_5678 ^ 32'(b)};
    endfunction

    function automatic logic [HW-1:0] head(input int s);
        return {32'hBEEF_0000 + 32'(s), 32'h0000_1111 * 32'(s)};
    endfunction

    task automatic refresh();
        adc_fifo_empty = (adc_q.size() == 0) || (head_q.size() == 0);
        adc_fifo_din   = (adc_q.size() != 0) ? adc_q[0] : '0;
        head_din       = (head_q.size() != 0) ? head_q[0] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Push one sample's head and first nw words; expect header plus nd data beats.
    task automatic sample(input int seq, input int s, input int nw, input int nd);
        beat_t e;
        head_q.push_back(head(s));
        for (int b = 0; b < nw; b++) adc_q.push_back(word(s, b));
        e.d = {32'hEB90_55AA, 32'(seq), head(s)};
        e.l = 1'b0;
        exp_q.push_back(e);
        for (int b = 0; b < nd; b++) begin
            e.d = word(s, b);
            exp_q.push_back(e);
        end
        refresh();
    endtask

    task automatic more_words(input int s, input int from, input int upto);
        for (int b = from; b <= upto; b++) adc_q.push_back(word(s, b));
        refresh();
    endtask

    task automatic exp_tail(input int seq, input int n);
        beat_t e;
        e.d = {32'hEB90_AA55, 32'(seq), 16'h0, 16'(n), 32'h0};
        e.l = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: %0d beats still expected, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic wait_pops(input string nm, input int target, input int base, input int budget);
        int n;
        n = 0;
        while (adc_pops - base < target && n < budget) begin
            tick();
            n++;
        end
        chk(nm, W'(adc_pops - base), W'(target));
    endtask

    always @(posedge clk) cyc++;

    // FWFT FIFO model: pops decided by the strobes the DUT held through the edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rd_s) begin
            adc_pops++;
            if (adc_q.size() == 0) chk("adc_pop_when_empty", W'(1), W'(0));
            else void'(adc_q.pop_front());
        end
        if (hrd_s) begin
            head_pops++;
            if (head_q.size() == 0) chk("head_pop_when_empty", W'(1), W'(0));
            else void'(head_q.pop_front());
        end
        refresh();
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // Monitor: compares each accepted beat against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        rd_s  = adc_fifo_rd;
        hrd_s = head_rd;
        if (stall_prev) begin
            chk("stall_valid", W'(m_axis_tvalid), W'(1));
            chk("stall_data", m_axis_tdata, prev_data);
            chk("stall_last", W'(m_axis_tlast), W'(prev_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", m_axis_tdata, '0);
                if (m_axis_tdata == '0) chk("unexpected_beat_valid", W'(1), W'(0));
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", m_axis_tdata, e.d);
                chk("beat_last", W'(m_axis_tlast), W'(e.l));
            end
            if (m_axis_tlast) tail_gap = cyc - prev_acc;
            prev_acc = cyc;
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    end

    initial begin
        int a0;
        int h0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_tvalid", W'(m_axis_tvalid), W'(0));
        chk("rst_tlast", W'(m_axis_tlast), W'(0));
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_pkt_cnt", W'(pkt_cnt), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        // Two preloaded samples, full packet, always ready
        a0 = adc_pops; h0 = head_pops;
        sample(0, 1, 4, 4);
        sample(0, 2, 4, 4);
        exp_tail(0, 2);
        wait_drain("t1_drain", 100);
        chk("t1_pkt_cnt", W'(pkt_cnt), W'(1));
        chk("t1_adc_pops", W'(adc_pops - a0), W'(8));
        chk("t1_head_pops", W'(head_pops - h0), W'(2));
        chk("t1_busy", W'(busy), W'(0));

        // Same traffic under random backpressure
        a0 = adc_pops; h0 = head_pops;
        rand_ready = 1'b1;
        sample(1, 3, 4, 4);
        sample(1, 4, 4, 4);
        exp_tail(1, 2);
        wait_drain("t2_drain", 400);
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("t2_pkt_cnt", W'(pkt_cnt), W'(2));
        chk("t2_adc_pops", W'(adc_pops - a0), W'(8));
        chk("t2_head_pops", W'(head_pops - h0), W'(2));

        // Single sample then idle: partial packet flushed by timeout
        sample(2, 5, 4, 4);
        exp_tail(2, 1);
        wait_drain("t3_drain", FTO + 100);
        total++;
        if (tail_gap != FTO && tail_gap != FTO + 1) begin
            bad++;
            $display("FAIL t3_flush_gap actual=%0d required=%0d..%0d", tail_gap, FTO, FTO + 1);
        end
        chk("t3_pkt_cnt", W'(pkt_cnt), W'(3));
        chk("t3_busy", W'(busy), W'(0));

        // FIFO runs dry after D1: hold in DAT without pops, then resume
        a0 = adc_pops; h0 = head_pops;
        sample(3, 10, 2, 4);
        wait_pops("t4_d1_popped", 2, a0, 50);
        repeat (20) tick();
        chk("t4_stall_adc_pops", W'(adc_pops - a0), W'(2));
        chk("t4_stall_head_pops", W'(head_pops - h0), W'(0));
        chk("t4_stall_tvalid", W'(m_axis_tvalid), W'(0));
        chk("t4_stall_busy", W'(busy), W'(1));
        more_words(10, 2, 3);
        wait_pops("t4_d2_popped", 3, a0, 20);
        chk("t4_no_head_on_d2", W'(head_pops - h0), W'(0));
        wait_pops("t4_d3_popped", 4, a0, 20);
        chk("t4_head_on_d3", W'(head_pops - h0), W'(1));
        sample(3, 11, 4, 4);
        exp_tail(3, 2);
        wait_drain("t4_drain", 100);
        chk("t4_pkt_cnt", W'(pkt_cnt), W'(4));

        // Soft clear mid-DAT abandons the packet and restarts sequence numbering
        sample(4, 20, 2, 2);
        wait_drain("t5_partial", 50);
        chk("t5_busy_before", W'(busy), W'(1));
        cfg_rst = 1'b1;
        chk("t5_no_pop_in_clear", W'(adc_fifo_rd), W'(0));
        adc_q.delete();
        head_q.delete();
        refresh();
        tick();
        cfg_rst = 1'b0;
        chk("t5_tvalid", W'(m_axis_tvalid), W'(0));
        chk("t5_busy", W'(busy), W'(0));
        chk("t5_pkt_cnt", W'(pkt_cnt), W'(0));
        repeat (2) tick();

        // Three full packets back-to-back, sequence 0,1,2
        for (int p = 0; p < 3; p++) begin
            sample(p, 30 + 2 * p, 4, 4);
            sample(p, 31 + 2 * p, 4, 4);
            exp_tail(p, 2);
        end
        wait_drain("t6_drain", 200);
        chk("t6_pkt_cnt", W'(pkt_cnt), W'(3));
        chk("t6_busy", W'(busy), W'(0));
        chk("t6_fifo_left", W'(adc_q.size()), W'(0));

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
